// File: rtl/uart_frame_tx.sv
// Serial UART transmitter for a fixed-format numeric frame: BCD digits with an
// optional decimal point, then a unit character and an optional line feed.
module uart_frame_tx #(
  parameter int         CLK_HZ    = 50000000,
  parameter int         BAUD      = 9600,
  parameter int         N_DIGITS  = 4,
  parameter int         DP_POS    = 1,
  parameter logic [7:0] UNIT_CHAR = 8'h56,
  parameter int         LF_EN     = 1,
  parameter int         PARITY    = 0,
  parameter int         STOP_BITS = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [4*N_DIGITS-1:0] digits,
  output logic                  txd,
  output logic                  busy,
  output logic                  done
);

  localparam int DIV      = (CLK_HZ + BAUD / 2) / BAUD;
  localparam int CW       = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int UNIT_IDX = N_DIGITS + ((DP_POS > 0) ? 1 : 0);
  localparam int N_CHARS  = UNIT_IDX + 1 + ((LF_EN != 0) ? 1 : 0);

  localparam logic [CW-1:0] BAUD_LAST = CW'(DIV - 1);
  localparam logic [3:0]    LAST_CHAR = 4'(N_CHARS - 1);
  localparam logic [2:0]    LAST_STOP = 3'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    START_BIT  = 3'd1,
    DATA_BITS  = 3'd2,
    PARITY_BIT = 3'd3,
    STOP_BIT   = 3'd4
  } state_t;

  function automatic logic [7:0] digit_char(input logic [3:0] nib);
    if (nib <= 4'd9) begin
      return 8'h30 + {4'h0, nib};
    end else begin
      return 8'h3F;
    end
  endfunction

  // Character at position idx of the frame, built from the latched digit word.
  function automatic logic [7:0] char_at(input logic [3:0] idx,
                                         input logic [4*N_DIGITS-1:0] d);
    logic [7:0] c;
    int         i;
    int         dig;
    i   = int'(idx);
    c   = 8'h3F;
    dig = i;
    if ((DP_POS > 0) && (i == DP_POS)) begin
      c = 8'h2E;
    end else if (i == UNIT_IDX) begin
      c = UNIT_CHAR;
    end else if (i > UNIT_IDX) begin
      c = 8'h0A;
    end else begin
      if ((DP_POS > 0) && (i > DP_POS)) begin
        dig = i - 1;
      end else begin
        dig = i;
      end
      for (int k = 0; k < N_DIGITS; k++) begin
        if (k == dig) begin
          c = digit_char(d[4*(N_DIGITS-1-k) +: 4]);
        end else begin
          c = c;
        end
      end
    end
    return c;
  endfunction

  function automatic logic parity_bit(input logic [7:0] data);
    if (PARITY == 1) begin
      return ~^data;
    end else begin
      return ^data;
    end
  endfunction

  state_t                state_r, state_s;
  logic [CW-1:0]         baud_r, baud_s;
  logic [2:0]            bit_r, bit_s;
  logic [3:0]            idx_r, idx_s;
  logic [7:0]            char_r, char_s;
  logic [4*N_DIGITS-1:0] digits_r, digits_s;
  logic                  txd_r, txd_s;
  logic                  busy_r, busy_s;
  logic                  done_r, done_s;
  logic                  baud_last_s;

  assign baud_last_s = (baud_r == BAUD_LAST);

  // Next-state, counter and line-level logic; outputs are registered below.
  always_comb begin
    state_s  = state_r;
    baud_s   = baud_r;
    bit_s    = bit_r;
    idx_s    = idx_r;
    char_s   = char_r;
    digits_s = digits_r;
    done_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_s  = START_BIT;
          baud_s   = '0;
          bit_s    = 3'd0;
          idx_s    = 4'd0;
          digits_s = digits;
          char_s   = char_at(4'd0, digits);
        end else begin
          state_s = IDLE;
        end
      end
      START_BIT: begin
        if (baud_last_s) begin
          state_s = DATA_BITS;
          baud_s  = '0;
          bit_s   = 3'd0;
        end else begin
          baud_s = baud_r + CW'(1);
        end
      end
      DATA_BITS: begin
        if (baud_last_s) begin
          baud_s = '0;
          if (bit_r == 3'd7) begin
            bit_s = 3'd0;
            if (PARITY != 0) begin
              state_s = PARITY_BIT;
            end else begin
              state_s = STOP_BIT;
            end
          end else begin
            bit_s = bit_r + 3'd1;
          end
        end else begin
          baud_s = baud_r + CW'(1);
        end
      end
      PARITY_BIT: begin
        if (baud_last_s) begin
          state_s = STOP_BIT;
          baud_s  = '0;
          bit_s   = 3'd0;
        end else begin
          baud_s = baud_r + CW'(1);
        end
      end
      STOP_BIT: begin
        if (baud_last_s) begin
          baud_s = '0;
          if (bit_r == LAST_STOP) begin
            bit_s = 3'd0;
            if (idx_r == LAST_CHAR) begin
              state_s = IDLE;
              idx_s   = 4'd0;
              done_s  = 1'b1;
            end else begin
              state_s = START_BIT;
              idx_s   = idx_r + 4'd1;
              char_s  = char_at(idx_r + 4'd1, digits_r);
            end
          end else begin
            bit_s = bit_r + 3'd1;
          end
        end else begin
          baud_s = baud_r + CW'(1);
        end
      end
      default: begin
        state_s = IDLE;
        baud_s  = '0;
        bit_s   = 3'd0;
        idx_s   = 4'd0;
      end
    endcase

    // Line level follows the state being entered so txd is a clean flop output.
    case (state_s)
      IDLE:       txd_s = 1'b1;
      START_BIT:  txd_s = 1'b0;
      DATA_BITS:  txd_s = char_s[bit_s];
      PARITY_BIT: txd_s = parity_bit(char_s);
      STOP_BIT:   txd_s = 1'b1;
      default:    txd_s = 1'b1;
    endcase
    busy_s = (state_s != IDLE);
  end

  // State, counters, latched frame data and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= IDLE;
      baud_r   <= '0;
      bit_r    <= 3'd0;
      idx_r    <= 4'd0;
      char_r   <= 8'h00;
      digits_r <= '0;
      txd_r    <= 1'b1;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      state_r  <= state_s;
      baud_r   <= baud_s;
      bit_r    <= bit_s;
      idx_r    <= idx_s;
      char_r   <= char_s;
      digits_r <= digits_s;
      txd_r    <= txd_s;
      busy_r   <= busy_s;
      done_r   <= done_s;
    end
  end

  assign txd  = txd_r;
  assign busy = busy_r;
  assign done = done_r;

endmodule

// File: tb/tb_uart_frame_tx.sv
// Directed bench for uart_frame_tx: three configurations at DIV=10, each frame
// checked bit by bit against hand-built character lists.
module tb_uart_frame_tx;

  logic        clk;
  logic        rst;
  logic        start_a, start_p2, start_p1;
  logic [15:0] digits_a;
  logic [3:0]  digits_p2, digits_p1;
  logic        txd_a, busy_a, done_a;
  logic        txd_p2, busy_p2, done_p2;
  logic        txd_p1, busy_p1, done_p1;

  int          n_tests;
  int          n_fail;
  logic [7:0]  exp_chars [0:7];
  int          n_exp;

  uart_frame_tx #(.CLK_HZ(1000000), .BAUD(100000)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .digits(digits_a),
    .txd(txd_a), .busy(busy_a), .done(done_a)
  );

  uart_frame_tx #(.CLK_HZ(1000000), .BAUD(100000), .N_DIGITS(1), .DP_POS(0),
                  .LF_EN(0), .PARITY(2), .STOP_BITS(2)) dut_p2 (
    .clk(clk), .rst(rst), .start(start_p2), .digits(digits_p2),
    .txd(txd_p2), .busy(busy_p2), .done(done_p2)
  );

  uart_frame_tx #(.CLK_HZ(1000000), .BAUD(100000), .N_DIGITS(1), .DP_POS(0),
                  .LF_EN(0), .PARITY(1), .STOP_BITS(2)) dut_p1 (
    .clk(clk), .rst(rst), .start(start_p1), .digits(digits_p1),
    .txd(txd_p1), .busy(busy_p1), .done(done_p1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {done, busy, txd} of the selected instance
  function automatic logic [2:0] outs(input int sel);
    case (sel)
      0:       return {done_a, busy_a, txd_a};
      1:       return {done_p2, busy_p2, txd_p2};
      default: return {done_p1, busy_p1, txd_p1};
    endcase
  endfunction

  task automatic pulse_start(input int sel);
    case (sel)
      0:       start_a = 1'b1;
      1:       start_p2 = 1'b1;
      default: start_p1 = 1'b1;
    endcase
    @(negedge clk);
    start_a  = 1'b0;
    start_p2 = 1'b0;
    start_p1 = 1'b0;
  endtask

  // Entered at the falling edge of frame cycle 1; leaves at the falling edge of
  // the cycle after the last bit (or of cycle 'limit' when limit is nonzero).
  task automatic check_frame(input int sel, input int par, input int stops,
                             input int limit, input bit inject, input string name);
    int         cyc;
    int         nb;
    int         bad;
    logic [2:0] obs;
    logic [2:0] o;
    logic [7:0] ch;
    logic [11:0] fr;
    cyc = 1;
    for (int k = 0; k < n_exp; k++) begin
      ch      = exp_chars[k];
      fr      = '1;
      fr[0]   = 1'b0;
      fr[8:1] = ch;
      if (par != 0) begin
        fr[9] = (par == 1) ? ~^ch : ^ch;
        nb    = 10 + stops;
      end else begin
        nb    = 9 + stops;
      end
      for (int b = 0; b < nb; b++) begin
        bad = 0;
        obs = 3'b000;
        for (int t = 0; t < 10; t++) begin
          if (limit != 0 && cyc >= limit) return;
          if (inject && cyc == 50)  digits_a = 16'h0000;
          if (inject && cyc == 300) start_a = 1'b1;
          if (inject && cyc == 301) start_a = 1'b0;
          o = outs(sel);
          if (o !== {1'b0, 1'b1, fr[b]}) begin
            if (bad == 0) obs = o;
            bad++;
          end
          @(negedge clk);
          cyc++;
        end
        n_tests++;
        if (bad != 0) begin
          n_fail++;
          $display("FAIL %s char%0d bit%0d: {done,busy,txd}=%b in %0d cycles, expected %b",
                   name, k, b, obs, bad, {1'b0, 1'b1, fr[b]});
        end
      end
    end
  endtask

  task automatic set_chars(input logic [7:0] c0, c1, c2, c3, c4, c5, c6, input int n);
    exp_chars[0] = c0; exp_chars[1] = c1; exp_chars[2] = c2; exp_chars[3] = c3;
    exp_chars[4] = c4; exp_chars[5] = c5; exp_chars[6] = c6; exp_chars[7] = 8'h00;
    n_exp = n;
  endtask

  task automatic test_reset();
    for (int s = 0; s < 3; s++) begin
      n_tests++;
      if (outs(s) !== 3'b001) begin
        n_fail++;
        $display("FAIL reset_state dut%0d: {done,busy,txd}=%b, expected 001", s, outs(s));
      end
    end
    start_a = 1'b1;
    @(negedge clk);
    rst     = 1'b0;
    start_a = 1'b0;
    @(negedge clk);
    n_tests++;
    if (outs(0) !== 3'b001) begin
      n_fail++;
      $display("FAIL start_with_rst: {done,busy,txd}=%b, expected 001", outs(0));
    end
  endtask

  task automatic test_default_frame();
    digits_a = 16'h3301;
    set_chars(8'h33, 8'h2E, 8'h33, 8'h30, 8'h31, 8'h56, 8'h0A, 7);
    pulse_start(0);
    check_frame(0, 0, 1, 0, 1'b0, "default");
    n_tests++;
    if (outs(0) !== 3'b101) begin
      n_fail++;
      $display("FAIL default_done_701: {done,busy,txd}=%b, expected 101", outs(0));
    end
    @(negedge clk);
    n_tests++;
    if (outs(0) !== 3'b001) begin
      n_fail++;
      $display("FAIL default_idle_702: {done,busy,txd}=%b, expected 001", outs(0));
    end
  endtask

  task automatic test_parity(input int sel, input int par, input string name);
    set_chars(8'h31, 8'h56, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 2);
    pulse_start(sel);
    check_frame(sel, par, 2, 0, 1'b0, name);
    n_tests++;
    if (outs(sel) !== 3'b101) begin
      n_fail++;
      $display("FAIL %s_done_241: {done,busy,txd}=%b, expected 101", name, outs(sel));
    end
    @(negedge clk);
    n_tests++;
    if (outs(sel) !== 3'b001) begin
      n_fail++;
      $display("FAIL %s_idle_242: {done,busy,txd}=%b, expected 001", name, outs(sel));
    end
  endtask

  task automatic test_bad_digits();
    digits_a = 16'hA3F1;
    set_chars(8'h3F, 8'h2E, 8'h33, 8'h3F, 8'h31, 8'h56, 8'h0A, 7);
    pulse_start(0);
    check_frame(0, 0, 1, 0, 1'b1, "bad_digits");
    n_tests++;
    if (outs(0) !== 3'b101) begin
      n_fail++;
      $display("FAIL bad_digits_done: {done,busy,txd}=%b, expected 101", outs(0));
    end
    @(negedge clk);
    n_tests++;
    if (outs(0) !== 3'b001) begin
      n_fail++;
      $display("FAIL busy_start_queued: {done,busy,txd}=%b, expected 001", outs(0));
    end
  endtask

  task automatic test_reset_mid_frame();
    int bad;
    logic [2:0] obs;
    digits_a = 16'h3301;
    set_chars(8'h33, 8'h2E, 8'h33, 8'h30, 8'h31, 8'h56, 8'h0A, 7);
    pulse_start(0);
    check_frame(0, 0, 1, 150, 1'b0, "pre_reset");
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_tests++;
    if (outs(0) !== 3'b001) begin
      n_fail++;
      $display("FAIL abort_151: {done,busy,txd}=%b, expected 001", outs(0));
    end
    bad = 0;
    obs = 3'b001;
    for (int t = 0; t < 9; t++) begin
      @(negedge clk);
      if (outs(0) !== 3'b001) begin
        bad++;
        obs = outs(0);
      end
    end
    n_tests++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL abort_quiet: {done,busy,txd}=%b, expected 001", obs);
    end
    pulse_start(0);
    check_frame(0, 0, 1, 0, 1'b0, "post_reset");
    n_tests++;
    if (outs(0) !== 3'b101) begin
      n_fail++;
      $display("FAIL post_reset_done: {done,busy,txd}=%b, expected 101", outs(0));
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    digits_a = 16'h3301;
    set_chars(8'h33, 8'h2E, 8'h33, 8'h30, 8'h31, 8'h56, 8'h0A, 7);
    start_a = 1'b1;
    @(negedge clk);
    check_frame(0, 0, 1, 0, 1'b0, "b2b_first");
    n_tests++;
    if (outs(0) !== 3'b101) begin
      n_fail++;
      $display("FAIL b2b_gap: {done,busy,txd}=%b, expected 101", outs(0));
    end
    @(negedge clk);
    start_a = 1'b0;
    check_frame(0, 0, 1, 0, 1'b0, "b2b_second");
    n_tests++;
    if (outs(0) !== 3'b101) begin
      n_fail++;
      $display("FAIL b2b_second_done: {done,busy,txd}=%b, expected 101", outs(0));
    end
    @(negedge clk);
    n_tests++;
    if (outs(0) !== 3'b001) begin
      n_fail++;
      $display("FAIL b2b_idle: {done,busy,txd}=%b, expected 001", outs(0));
    end
  endtask

  initial begin
    n_tests   = 0;
    n_fail    = 0;
    n_exp     = 0;
    rst       = 1'b1;
    start_a   = 1'b0;
    start_p2  = 1'b0;
    start_p1  = 1'b0;
    digits_a  = 16'h0000;
    digits_p2 = 4'h1;
    digits_p1 = 4'h1;
    repeat (3) @(negedge clk);
    test_reset();
    test_default_frame();
    test_parity(1, 2, "parity_even");
    test_parity(2, 1, "parity_odd");
    test_bad_digits();
    test_reset_mid_frame();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
